// File: rtl/gray_arbiter.sv
// gray_arbiter: round-robin arbiter that lends one shared 3-bit Gray counter
// to one of four requesters for a burst of Len steps.
//
// Ports
//   Clk      in   clock, all state updates on the rising edge
//   Reset    in   asynchronous active-low reset
//   Req      in   [3:0] level-held per-requester request
//   Len      in   [2:0] burst length in counter steps (0 means 8), sampled at grant
//   Cnt_Ovf  in   overflow flag from the shared Gray counter
//   Gnt      out  [3:0] one-hot grant, zero while idle
//   Cnt_Clr  out  active-high clear for the counter, one cycle per burst
//   Cnt_En   out  counter step enable, follows Req[owner] while running
//   Busy     out  high whenever a burst is in progress
//   Done     out  one-cycle end-of-burst pulse
//   Done_Id  out  [1:0] finishing requester, valid with Done
//   Aborted  out  burst ended because the owner dropped its request, valid with Done
//   Wrap     out  counter overflow seen at end of burst, valid with Done
module gray_arbiter (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] Req,
  input  logic [2:0] Len,
  input  logic       Cnt_Ovf,
  output logic [3:0] Gnt,
  output logic       Cnt_Clr,
  output logic       Cnt_En,
  output logic       Busy,
  output logic       Done,
  output logic [1:0] Done_Id,
  output logic       Aborted,
  output logic       Wrap
);

  typedef enum logic [1:0] {StIdle, StClear, StRun, StDone} state_e;

  state_e     state_q;
  logic [1:0] ptr_q;
  logic [1:0] owner_q;
  logic [3:0] rem_q;
  logic       aborted_q;

  logic       pick_valid;
  logic [1:0] pick_idx;
  logic [1:0] scan_idx;
  logic       owner_req;

  // Round-robin search starting at ptr_q. Scanning offsets from high to low
  // lets the lowest offset (closest to ptr_q) overwrite the others.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = ptr_q;
    scan_idx   = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      scan_idx = ptr_q + 2'(i);
      if (Req[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign owner_req = Req[owner_q];

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q   <= StIdle;
      ptr_q     <= 2'd0;
      owner_q   <= 2'd0;
      rem_q     <= 4'd0;
      aborted_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_valid) begin
            owner_q   <= pick_idx;
            rem_q     <= (Len == 3'd0) ? 4'd8 : {1'b0, Len};
            aborted_q <= 1'b0;
            state_q   <= StClear;
          end
        end
        StClear: begin
          state_q <= StRun;
        end
        StRun: begin
          if (!owner_req) begin
            // Owner walked away: end the burst without issuing a step.
            aborted_q <= 1'b1;
            state_q   <= StDone;
          end else begin
            rem_q <= rem_q - 4'd1;
            if (rem_q == 4'd1) begin
              state_q <= StDone;
            end
          end
        end
        StDone: begin
          ptr_q   <= owner_q + 2'd1;
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs decode from state registers; Cnt_En is the one path that follows
  // Req so an abort issues no step in the dropping cycle. Wrap reflects the
  // counter's flag after the final step has landed.
  assign Busy    = (state_q != StIdle);
  assign Gnt     = Busy ? (4'b0001 << owner_q) : 4'b0000;
  assign Cnt_Clr = (state_q == StClear);
  assign Cnt_En  = (state_q == StRun) & owner_req;
  assign Done    = (state_q == StDone);
  assign Done_Id = Done ? owner_q : 2'd0;
  assign Aborted = Done & aborted_q;
  assign Wrap    = Done & Cnt_Ovf;

endmodule

// File: tb/tb_gray_arbiter.sv
module tb_gray_arbiter;

  logic       Clk;
  logic       Reset;
  logic [3:0] Req;
  logic [2:0] Len;
  logic       Cnt_Ovf;
  logic [3:0] Gnt;
  logic       Cnt_Clr;
  logic       Cnt_En;
  logic       Busy;
  logic       Done;
  logic [1:0] Done_Id;
  logic       Aborted;
  logic       Wrap;

  gray_arbiter dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .Req     (Req),
    .Len     (Len),
    .Cnt_Ovf (Cnt_Ovf),
    .Gnt     (Gnt),
    .Cnt_Clr (Cnt_Clr),
    .Cnt_En  (Cnt_En),
    .Busy    (Busy),
    .Done    (Done),
    .Done_Id (Done_Id),
    .Aborted (Aborted),
    .Wrap    (Wrap)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Shared 3-bit Gray counter model with sticky overflow, cleared by Cnt_Clr.
  logic [2:0] cnt_m = 3'd0;
  logic       ovf_m = 1'b0;
  assign Cnt_Ovf = ovf_m;

  function automatic logic [2:0] gray_inc(input logic [2:0] g);
    logic [2:0] b;
    b = g ^ (g >> 1) ^ (g >> 2);
    b = b + 3'd1;
    return b ^ (b >> 1);
  endfunction

  always @(posedge Clk) begin
    if (Cnt_Clr) begin
      cnt_m <= 3'd0;
      ovf_m <= 1'b0;
    end else if (Cnt_En) begin
      cnt_m <= gray_inc(cnt_m);
      if (cnt_m == 3'b100) ovf_m <= 1'b1;
    end
  end

  // Scoreboard of expected end-of-burst reports.
  typedef struct {
    logic [1:0] id;
    logic       ab;
    logic       wr;
  } exp_t;
  exp_t sb[$];

  always @(negedge Clk) begin
    chk("gnt_onehot", 8'($countones(Gnt) <= 1), 8'd1);
    chk("clr_en_excl", 8'(Cnt_Clr & Cnt_En), 8'd0);
    if (Done) begin
      if (sb.size() == 0) begin
        chk("done_unexpected", 8'(Done), 8'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("done_id", 8'(Done_Id), 8'(e.id));
        chk("done_aborted", 8'(Aborted), 8'(e.ab));
        chk("done_wrap", 8'(Wrap), 8'(e.wr));
      end
    end
  end

  int ord[5] = '{0, 1, 2, 3, 0};
  int n_en;
  logic seen;

  initial begin
    Reset = 1'b0;
    Req   = 4'd0;
    Len   = 3'd0;
    #2;
    chk("rst_gnt", 8'(Gnt), 8'd0);
    chk("rst_busy", 8'(Busy), 8'd0);
    chk("rst_clr", 8'(Cnt_Clr), 8'd0);
    chk("rst_en", 8'(Cnt_En), 8'd0);
    chk("rst_done", 8'(Done), 8'd0);
    chk("rst_done_id", 8'(Done_Id), 8'd0);
    chk("rst_aborted", 8'(Aborted), 8'd0);
    chk("rst_wrap", 8'(Wrap), 8'd0);
    @(negedge Clk);
    @(negedge Clk);
    Reset = 1'b1;

    // Basic burst of 3 steps from requester 0.
    @(negedge Clk);
    Req = 4'b0001;
    Len = 3'd3;
    sb.push_back('{2'd0, 1'b0, 1'b0});
    @(negedge Clk);
    chk("b3_clr", 8'(Cnt_Clr), 8'd1);
    chk("b3_clr_en", 8'(Cnt_En), 8'd0);
    chk("b3_gnt", 8'(Gnt), 8'h01);
    chk("b3_busy", 8'(Busy), 8'd1);
    repeat (3) begin
      @(negedge Clk);
      chk("b3_en", 8'(Cnt_En), 8'd1);
      chk("b3_run_clr", 8'(Cnt_Clr), 8'd0);
    end
    @(negedge Clk);
    chk("b3_done", 8'(Done), 8'd1);
    chk("b3_done_en", 8'(Cnt_En), 8'd0);
    Req = 4'd0;
    @(negedge Clk);
    chk("b3_idle_gnt", 8'(Gnt), 8'd0);
    chk("b3_idle_busy", 8'(Busy), 8'd0);

    // Len=0 gives 8 steps and a counter wrap.
    @(negedge Clk);
    Req = 4'b0001;
    Len = 3'd0;
    sb.push_back('{2'd0, 1'b0, 1'b1});
    n_en = 0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge Clk);
      if (Cnt_En) n_en++;
      if (Done) seen = 1'b1;
    end
    Req = 4'd0;
    chk("wrap_seen", 8'(seen), 8'd1);
    chk("wrap_steps", 8'(n_en), 8'd8);
    chk("wrap_cnt", 8'(cnt_m), 8'd0);
    @(negedge Clk);

    // Reset pulse while idle returns the pointer to 0.
    Reset = 1'b0;
    @(negedge Clk);
    Reset = 1'b1;

    // All four requesting, Len=1: rotation 0,1,2,3,0 with 4-cycle bursts.
    Req = 4'b1111;
    Len = 3'd1;
    for (int j = 0; j < 5; j++) sb.push_back('{2'(ord[j]), 1'b0, 1'b0});
    for (int c = 1; c <= 19; c++) begin
      @(negedge Clk);
      if (c % 4 == 1) begin
        chk("rot_gnt", 8'(Gnt), 8'(1 << ord[c / 4]));
        chk("rot_clr", 8'(Cnt_Clr), 8'd1);
      end
      if (c % 4 == 0) chk("rot_idle", 8'(Gnt), 8'd0);
      if (c == 17) Req = 4'b0001;
      if (c == 19) Req = 4'd0;
    end
    @(negedge Clk);

    // Requester 2 drops its request after 2 of 5 steps.
    Req = 4'b0100;
    Len = 3'd5;
    sb.push_back('{2'd2, 1'b1, 1'b0});
    @(negedge Clk);
    chk("ab_gnt", 8'(Gnt), 8'h04);
    repeat (2) begin
      @(negedge Clk);
      chk("ab_en", 8'(Cnt_En), 8'd1);
    end
    @(negedge Clk);
    Req = 4'd0;
    #1;
    chk("ab_en_drop", 8'(Cnt_En), 8'd0);
    chk("ab_busy", 8'(Busy), 8'd1);
    @(negedge Clk);
    chk("ab_done", 8'(Done), 8'd1);
    chk("ab_cnt", 8'(cnt_m), 8'h03);
    @(negedge Clk);
    chk("ab_idle", 8'(Busy), 8'd0);

    // Pointer now 3: Req=0110 must go to requester 1.
    Req = 4'b0110;
    Len = 3'd1;
    sb.push_back('{2'd1, 1'b0, 1'b0});
    @(negedge Clk);
    chk("ptr_gnt", 8'(Gnt), 8'h02);
    @(negedge Clk);
    @(negedge Clk);
    chk("ptr_done", 8'(Done), 8'd1);
    Req = 4'd0;
    @(negedge Clk);

    // Reset mid-burst: outputs drop at once, no Done, search restarts at 0.
    Req = 4'b0001;
    Len = 3'd7;
    @(negedge Clk);
    @(negedge Clk);
    @(negedge Clk);
    chk("mid_running", 8'(Cnt_En), 8'd1);
    #2;
    Reset = 1'b0;
    #1;
    chk("mid_gnt", 8'(Gnt), 8'd0);
    chk("mid_busy", 8'(Busy), 8'd0);
    chk("mid_en", 8'(Cnt_En), 8'd0);
    chk("mid_clr", 8'(Cnt_Clr), 8'd0);
    chk("mid_done", 8'(Done), 8'd0);
    Req = 4'd0;
    repeat (2) @(negedge Clk);
    chk("mid_hold_done", 8'(Done), 8'd0);
    Reset = 1'b1;
    @(negedge Clk);
    Req = 4'b1000;
    Len = 3'd1;
    sb.push_back('{2'd3, 1'b0, 1'b0});
    @(negedge Clk);
    chk("post_rst_gnt", 8'(Gnt), 8'h08);
    @(negedge Clk);
    @(negedge Clk);
    chk("post_rst_done", 8'(Done), 8'd1);
    Req = 4'd0;

    repeat (3) @(negedge Clk);
    chk("sb_empty", 8'(sb.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
